// File: rtl/video_to_sensor.sv
// video_to_sensor
// ---------------------------------------------------------------------------
// DVP-style sensor source emulator. Generates vsyn/href/data frames with a
// geometry set at runtime and a selectable test pattern. It is the transmit
// end of the interface that sensor_to_video receives. It emits one beat per
// i_sys_clk, so a consumer uses i_sys_clk as its pixel clock.
//
// Ports
//   i_sys_clk, i_sys_reset    : clock and synchronous active-high reset
//   s_ctrl_run                : generate frames continuously (sampled in IDLE
//                               and when a frame gap ends)
//   s_cinfo_line_pixl         : active pixels per line
//   s_cinfo_fram_line         : lines per frame
//   s_cinfo_hblk_cunt         : href-low cycles before each line
//   s_cinfo_vblk_cunt         : vertical porch and frame gap length
//   s_cinfo_patt_mode         : 0 line index, 1 pixel ramp, 2 constant,
//                               3 checker
//   s_cinfo_patt_cnst         : constant used by pattern mode 2
//   m_sensor_dst_vsyn/href/data : sensor bus (all registered)
//   m_vinfo_dst_fcunt         : completed-frame counter (wraps)
//   m_vinfo_dst_lcunt         : current line index, 0-based
//   m_ctrl_busy               : high whenever the FSM is not IDLE
//   m_err_config              : one-cycle pulse per rejected start attempt
//
// Handshake: there is no backpressure. Each cycle with vsyn=1 and href=1
// carries one valid pixel on m_sensor_dst_data; the consumer must accept it.
//
// Optional feature: macro VIDEO_TO_SENSOR_BLANK_ZERO_EN
//   defined   : data is driven to 0 on every cycle with href=0
//   undefined : data holds the last active pixel through blanking
//
// WD_SENSOR_DATA must not exceed WD_CONFIG_INFO. The pattern slices the line
// and pixel counters down to the data width.
// ---------------------------------------------------------------------------
module video_to_sensor #(
  parameter int WD_CONFIG_INFO = 16,
  parameter int WD_SENSOR_DATA = 8,
  parameter int WD_VIDEO_INFO  = 16
) (
  input  logic                      i_sys_clk,
  input  logic                      i_sys_reset,
  input  logic                      s_ctrl_run,
  input  logic [WD_CONFIG_INFO-1:0] s_cinfo_line_pixl,
  input  logic [WD_CONFIG_INFO-1:0] s_cinfo_fram_line,
  input  logic [WD_CONFIG_INFO-1:0] s_cinfo_hblk_cunt,
  input  logic [WD_CONFIG_INFO-1:0] s_cinfo_vblk_cunt,
  input  logic [1:0]                s_cinfo_patt_mode,
  input  logic [WD_SENSOR_DATA-1:0] s_cinfo_patt_cnst,
  output logic                      m_sensor_dst_vsyn,
  output logic                      m_sensor_dst_href,
  output logic [WD_SENSOR_DATA-1:0] m_sensor_dst_data,
  output logic [WD_VIDEO_INFO-1:0]  m_vinfo_dst_fcunt,
  output logic [WD_CONFIG_INFO-1:0] m_vinfo_dst_lcunt,
  output logic                      m_ctrl_busy,
  output logic                      m_err_config
);

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_VS_PRE   = 3'd1,
    ST_H_BLANK  = 3'd2,
    ST_H_ACTIVE = 3'd3,
    ST_VS_POST  = 3'd4,
    ST_F_GAP    = 3'd5
  } state_t;

  localparam logic [WD_CONFIG_INFO-1:0] CFG_ONE = {{(WD_CONFIG_INFO-1){1'b0}}, 1'b1};
  localparam logic [WD_VIDEO_INFO-1:0]  VID_ONE = {{(WD_VIDEO_INFO-1){1'b0}}, 1'b1};

  state_t                    state_q, state_d;
  logic [WD_CONFIG_INFO-1:0] cnt_q, cnt_d;      // cycle index within state
  logic [WD_CONFIG_INFO-1:0] lcunt_q, lcunt_d;
  logic [WD_VIDEO_INFO-1:0]  fcunt_q, fcunt_d;

  // Frame configuration, latched when a frame starts.
  logic [WD_CONFIG_INFO-1:0] pixl_q, pixl_d;
  logic [WD_CONFIG_INFO-1:0] line_q, line_d;
  logic [WD_CONFIG_INFO-1:0] hblk_q, hblk_d;
  logic [WD_CONFIG_INFO-1:0] vblk_q, vblk_d;
  logic [1:0]                mode_q, mode_d;
  logic [WD_SENSOR_DATA-1:0] cnst_q, cnst_d;

  logic                      vsyn_q, vsyn_d;
  logic                      href_q, href_d;
  logic [WD_SENSOR_DATA-1:0] data_q, data_d;
  logic                      busy_q, busy_d;
  logic                      err_q, err_d;

  logic cfg_ok;
  logic start;

  assign cfg_ok = (s_cinfo_line_pixl != '0) && (s_cinfo_fram_line != '0) &&
                  (s_cinfo_hblk_cunt != '0) && (s_cinfo_vblk_cunt != '0);
  assign start  = s_ctrl_run && cfg_ok;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    lcunt_d = lcunt_q;
    fcunt_d = fcunt_q;
    pixl_d  = pixl_q;
    line_d  = line_q;
    hblk_d  = hblk_q;
    vblk_d  = vblk_q;
    mode_d  = mode_q;
    cnst_d  = cnst_q;
    err_d   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        if (start) begin
          state_d = ST_VS_PRE;
          lcunt_d = '0;
          pixl_d  = s_cinfo_line_pixl;
          line_d  = s_cinfo_fram_line;
          hblk_d  = s_cinfo_hblk_cunt;
          vblk_d  = s_cinfo_vblk_cunt;
          mode_d  = s_cinfo_patt_mode;
          cnst_d  = s_cinfo_patt_cnst;
        end else if (s_ctrl_run) begin
          err_d = 1'b1;
        end
      end
      // Latched geometry is never zero, so "value - 1" cannot underflow.
      ST_VS_PRE: begin
        if (cnt_q == vblk_q - CFG_ONE) begin
          state_d = ST_H_BLANK;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CFG_ONE;
        end
      end
      ST_H_BLANK: begin
        if (cnt_q == hblk_q - CFG_ONE) begin
          state_d = ST_H_ACTIVE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CFG_ONE;
        end
      end
      ST_H_ACTIVE: begin
        if (cnt_q == pixl_q - CFG_ONE) begin
          cnt_d = '0;
          if (lcunt_q == line_q - CFG_ONE) begin
            state_d = ST_VS_POST;
          end else begin
            state_d = ST_H_BLANK;
            lcunt_d = lcunt_q + CFG_ONE;
          end
        end else begin
          cnt_d = cnt_q + CFG_ONE;
        end
      end
      ST_VS_POST: begin
        if (cnt_q == vblk_q - CFG_ONE) begin
          // The frame is complete at the vsyn falling edge.
          state_d = ST_F_GAP;
          cnt_d   = '0;
          fcunt_d = fcunt_q + VID_ONE;
        end else begin
          cnt_d = cnt_q + CFG_ONE;
        end
      end
      ST_F_GAP: begin
        if (cnt_q == vblk_q - CFG_ONE) begin
          cnt_d = '0;
          if (start) begin
            // Back-to-back frames re-latch the configuration.
            state_d = ST_VS_PRE;
            lcunt_d = '0;
            pixl_d  = s_cinfo_line_pixl;
            line_d  = s_cinfo_fram_line;
            hblk_d  = s_cinfo_hblk_cunt;
            vblk_d  = s_cinfo_vblk_cunt;
            mode_d  = s_cinfo_patt_mode;
            cnst_d  = s_cinfo_patt_cnst;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          cnt_d = cnt_q + CFG_ONE;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase

    // Outputs are registered. They are decoded from the next state so that
    // each bus value lines up with the state it describes.
    vsyn_d = (state_d == ST_VS_PRE) || (state_d == ST_H_BLANK) ||
             (state_d == ST_H_ACTIVE) || (state_d == ST_VS_POST);
    href_d = (state_d == ST_H_ACTIVE);
    busy_d = (state_d != ST_IDLE);

`ifdef VIDEO_TO_SENSOR_BLANK_ZERO_EN
    data_d = '0;
`else
    data_d = data_q;
`endif
    if (href_d) begin
      case (mode_q)
        2'd0:    data_d = lcunt_d[WD_SENSOR_DATA-1:0];
        2'd1:    data_d = cnt_d[WD_SENSOR_DATA-1:0];
        2'd2:    data_d = cnst_q;
        default: data_d = {WD_SENSOR_DATA{lcunt_d[0] ^ cnt_d[0]}};
      endcase
    end
  end

  always_ff @(posedge i_sys_clk) begin
    if (i_sys_reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      lcunt_q <= '0;
      fcunt_q <= '0;
      pixl_q  <= '0;
      line_q  <= '0;
      hblk_q  <= '0;
      vblk_q  <= '0;
      mode_q  <= '0;
      cnst_q  <= '0;
      vsyn_q  <= 1'b0;
      href_q  <= 1'b0;
      data_q  <= '0;
      busy_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      lcunt_q <= lcunt_d;
      fcunt_q <= fcunt_d;
      pixl_q  <= pixl_d;
      line_q  <= line_d;
      hblk_q  <= hblk_d;
      vblk_q  <= vblk_d;
      mode_q  <= mode_d;
      cnst_q  <= cnst_d;
      vsyn_q  <= vsyn_d;
      href_q  <= href_d;
      data_q  <= data_d;
      busy_q  <= busy_d;
      err_q   <= err_d;
    end
  end

  assign m_sensor_dst_vsyn = vsyn_q;
  assign m_sensor_dst_href = href_q;
  assign m_sensor_dst_data = data_q;
  assign m_vinfo_dst_fcunt = fcunt_q;
  assign m_vinfo_dst_lcunt = lcunt_q;
  assign m_ctrl_busy       = busy_q;
  assign m_err_config      = err_q;

endmodule

// File: tb/tb_video_to_sensor.sv
// Directed testbench for video_to_sensor.
module tb_video_to_sensor;

  logic        clk;
  logic        rst;
  logic        run;
  logic [15:0] line_pixl;
  logic [15:0] fram_line;
  logic [15:0] hblk;
  logic [15:0] vblk;
  logic [1:0]  mode;
  logic [7:0]  cnst;
  logic        vsyn;
  logic        href;
  logic [7:0]  data;
  logic [15:0] fcunt;
  logic [15:0] lcunt;
  logic        busy;
  logic        err;

  int checks = 0;
  int passes = 0;

  // Monitor records.
  logic [7:0]  act_q[$];
  logic [7:0]  exp_q[$];
  logic [15:0] lc_q[$];
  int          vs_hi_q[$];
  int          vs_lo_q[$];
  int          href_len_q[$];
  int          vs_hi, vs_lo, href_len;
  int          blank_bad;
  logic [7:0]  last_data;

  video_to_sensor #(
    .WD_CONFIG_INFO(16),
    .WD_SENSOR_DATA(8),
    .WD_VIDEO_INFO (16)
  ) dut (
    .i_sys_clk        (clk),
    .i_sys_reset      (rst),
    .s_ctrl_run       (run),
    .s_cinfo_line_pixl(line_pixl),
    .s_cinfo_fram_line(fram_line),
    .s_cinfo_hblk_cunt(hblk),
    .s_cinfo_vblk_cunt(vblk),
    .s_cinfo_patt_mode(mode),
    .s_cinfo_patt_cnst(cnst),
    .m_sensor_dst_vsyn(vsyn),
    .m_sensor_dst_href(href),
    .m_sensor_dst_data(data),
    .m_vinfo_dst_fcunt(fcunt),
    .m_vinfo_dst_lcunt(lcunt),
    .m_ctrl_busy      (busy),
    .m_err_config     (err)
  );

  // Clock and reset.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Monitor: samples on the falling edge, away from the active edge.
  always @(negedge clk) begin
    if (rst) begin
      last_data = '0;
      vs_hi     = 0;
      vs_lo     = 0;
      href_len  = 0;
    end else begin
      if (href) begin
        act_q.push_back(data);
        lc_q.push_back(lcunt);
        last_data = data;
        href_len++;
      end else begin
`ifdef VIDEO_TO_SENSOR_BLANK_ZERO_EN
        if (data !== 8'h00) blank_bad++;
`else
        if (data !== last_data) blank_bad++;
`endif
        if (href_len != 0) begin
          href_len_q.push_back(href_len);
          href_len = 0;
        end
      end
      if (vsyn) begin
        vs_hi++;
        if (vs_lo != 0) begin
          vs_lo_q.push_back(vs_lo);
          vs_lo = 0;
        end
      end else begin
        if (vs_hi != 0) begin
          vs_hi_q.push_back(vs_hi);
          vs_hi = 0;
        end
        if (busy) vs_lo++;
        else      vs_lo = 0;
      end
    end
  end

  // Driver tasks.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    assert (act === exp) passes++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, act, exp);
  endtask

  task automatic clear_logs();
    act_q.delete();
    lc_q.delete();
    vs_hi_q.delete();
    vs_lo_q.delete();
    href_len_q.delete();
  endtask

  task automatic compare_data(input string tag);
    check({tag, "_beats"}, act_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < act_q.size(); i++)
      check($sformatf("%s_beat%0d", tag, i), act_q[i], exp_q[i]);
  endtask

  // Starts one frame, perturbs the config mid-frame (must be ignored),
  // drops run and waits for the frame to finish.
  task automatic run_frame(input int pix, input int lines, input int hb, input int vb,
                           input logic [1:0] md, input logic [7:0] cn);
    int n;
    clear_logs();
    line_pixl = 16'(pix);
    fram_line = 16'(lines);
    hblk      = 16'(hb);
    vblk      = 16'(vb);
    mode      = md;
    cnst      = cn;
    run       = 1'b1;
    tick();
    check("start_vsyn", vsyn, 1'b1);
    run       = 1'b0;
    line_pixl = 16'(pix + 3);
    fram_line = 16'(lines + 1);
    mode      = md + 2'd1;
    cnst      = ~cn;
    n = 0;
    while (busy && n < 2000) begin
      tick();
      n++;
    end
    check("frame_done", (n < 2000), 1'b1);
    check("vsyn_high_len", (vs_hi_q.size() == 1) ? vs_hi_q[0] : -1,
          2 * vb + lines * (hb + pix));
    check("href_pulses", href_len_q.size(), lines);
  endtask

  initial begin
    int n;
    blank_bad = 0;
    rst       = 1'b1;
    run       = 1'b0;
    line_pixl = '0;
    fram_line = '0;
    hblk      = '0;
    vblk      = '0;
    mode      = '0;
    cnst      = '0;
    repeat (3) tick();
    rst = 1'b0;
    tick();

    // Reset state.
    check("rst_vsyn", vsyn, 1'b0);
    check("rst_href", href, 1'b0);
    check("rst_data", data, 8'h00);
    check("rst_fcunt", fcunt, 16'd0);
    check("rst_lcunt", lcunt, 16'd0);
    check("rst_busy", busy, 1'b0);
    check("rst_err", err, 1'b0);

    // Reset asserted in the middle of an active line.
    line_pixl = 16'd4; fram_line = 16'd3; hblk = 16'd2; vblk = 16'd3;
    mode = 2'd1; cnst = 8'h00;
    run = 1'b1;
    tick();
    run = 1'b0;
    n = 0;
    while (!href && n < 100) begin
      tick();
      n++;
    end
    check("midline_reached", href, 1'b1);
    tick();
    rst = 1'b1;
    tick();
    check("mrst_vsyn", vsyn, 1'b0);
    check("mrst_href", href, 1'b0);
    check("mrst_data", data, 8'h00);
    check("mrst_busy", busy, 1'b0);
    check("mrst_fcunt", fcunt, 16'd0);
    check("mrst_lcunt", lcunt, 16'd0);
    rst = 1'b0;
    tick();
    check("mrst_idle_vsyn", vsyn, 1'b0);
    check("mrst_idle_data", data, 8'h00);

    // Rejected config: fram_line = 0.
    fram_line = 16'd0;
    run = 1'b1;
    tick();
    check("err_pulse0", err, 1'b1);
    check("err_vsyn", vsyn, 1'b0);
    check("err_busy", busy, 1'b0);
    tick();
    check("err_pulse1", err, 1'b1);
    check("err_vsyn1", vsyn, 1'b0);
    clear_logs();
    fram_line = 16'd3;
    tick();
    check("fix_vsyn", vsyn, 1'b1);
    check("fix_busy", busy, 1'b1);
    check("fix_err", err, 1'b0);

    // Back-to-back mode-1 frames: 4 pix, 3 lines, hblk 2, vblk 3.
    n = 0;
    while (fcunt != 16'd2 && n < 200) begin
      tick();
      n++;
    end
    check("two_frames", fcunt, 16'd2);
    run = 1'b0;
    n = 0;
    while (busy && n < 50) begin
      tick();
      n++;
    end
    check("busy_fall_after_gap", n, 3);
    check("vsyn_frames", vs_hi_q.size(), 2);
    for (int i = 0; i < 2 && i < vs_hi_q.size(); i++)
      check($sformatf("vsyn_len%0d", i), vs_hi_q[i], 24);
    check("gap_count", vs_lo_q.size(), 1);
    if (vs_lo_q.size() > 0) check("gap_len", vs_lo_q[0], 3);
    check("ramp_href_pulses", href_len_q.size(), 6);
    for (int i = 0; i < href_len_q.size(); i++)
      check($sformatf("ramp_href_len%0d", i), href_len_q[i], 4);
    exp_q.delete();
    for (int f = 0; f < 2; f++)
      for (int l = 0; l < 3; l++)
        for (int p = 0; p < 4; p++) exp_q.push_back(8'(p));
    compare_data("ramp");

    // Checker 4x2.
    run_frame(4, 2, 2, 3, 2'd3, 8'h00);
    exp_q = '{8'h00, 8'hFF, 8'h00, 8'hFF, 8'hFF, 8'h00, 8'hFF, 8'h00};
    compare_data("checker");
    check("checker_fcunt", fcunt, 16'd3);

    // Constant 0xA5, 3x2.
    run_frame(3, 2, 1, 2, 2'd2, 8'hA5);
    exp_q = '{8'hA5, 8'hA5, 8'hA5, 8'hA5, 8'hA5, 8'hA5};
    compare_data("const");
    check("const_fcunt", fcunt, 16'd4);

    // Line index 3x3; lcunt port must follow the line too.
    run_frame(3, 3, 2, 1, 2'd0, 8'h00);
    exp_q = '{8'd0, 8'd0, 8'd0, 8'd1, 8'd1, 8'd1, 8'd2, 8'd2, 8'd2};
    compare_data("lineidx");
    check("lc_beats", lc_q.size(), 9);
    for (int i = 0; i < 9 && i < lc_q.size(); i++)
      check($sformatf("lc_beat%0d", i), lc_q[i], 16'(i / 3));
    check("lineidx_fcunt", fcunt, 16'd5);

    check("blank_data", blank_bad, 0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
